unibus_mem: RTL and testbench

UNIBUS_MEM -- requirements
Module: unibus_mem

---
 rtl/unibus_mem_if.sv | 29 ++
 rtl/unibus_mem.sv | 155 +++++++++++++++
 tb/tb_unibus_mem.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/unibus_mem_if.sv
`default_nettype none
// ============================================================================
// Module      : unibus_mem_if
// Description : Unibus slave-side signal bundle (INIT, address, control,
//               MSYN/SSYN handshake and data lines).
// Revision    : 1.0 - initial release
// ============================================================================
interface unibus_mem_if;
    logic        bus_init;
    logic [17:0] bus_addr;
    logic        bus_c1;
    logic        bus_c0;
    logic        bus_msyn;
    logic [15:0] bus_d_in;
    logic [15:0] bus_d_out;
    logic        bus_d_en;
    logic        bus_ssyn_out;

    modport master (
        output bus_init, bus_addr, bus_c1, bus_c0, bus_msyn, bus_d_in,
        input  bus_d_out, bus_d_en, bus_ssyn_out
    );

    modport slave (
        input  bus_init, bus_addr, bus_c1, bus_c0, bus_msyn, bus_d_in,
        output bus_d_out, bus_d_en, bus_ssyn_out
    );
endinterface
`default_nettype wire

// File: rtl/unibus_mem.sv
`default_nettype none
// ============================================================================
// Module      : unibus_mem
// Description : Unibus memory slave. Deskews MSYN, decodes a word window,
//               issues one RAM request per bus cycle and answers with SSYN.
//               Reports DATIP read-modify-write locks on dip_lock.
// Revision    : 1.0 - initial release
// ============================================================================
module unibus_mem #(
    parameter logic [17:0] BASE   = 18'o000000,
    parameter int          WORDS  = 8192,
    parameter int          DESKEW = 4
) (
    input  wire logic                       clk,
    input  wire logic                       reset,
    unibus_mem_if.slave                     bus,
    output logic                            mem_req,
    output logic                            mem_we,
    output logic [1:0]                      mem_be,
    output logic [$clog2(WORDS)-1:0]        mem_addr,
    output logic [15:0]                     mem_wdata,
    input  wire logic [15:0]                mem_rdata,
    input  wire logic                       mem_ack,
    output logic                            dip_lock
);

    localparam int AW = $clog2(WORDS);
    localparam int CW = (DESKEW > 1) ? $clog2(DESKEW) : 1;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_DESKEW  = 3'd1;
    localparam logic [2:0] S_ACCESS  = 3'd2;
    localparam logic [2:0] S_RESPOND = 3'd3;
    localparam logic [2:0] S_RELEASE = 3'd4;

    localparam logic [1:0] C_DATIP = 2'b01;
    localparam logic [1:0] C_DATOB = 2'b11;

    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic [1:0]    cyc;

    logic [1:0]    cyc_in;
    logic [17:0]   offset;
    logic          selected;
    logic          deskew_done;
    logic [1:0]    be_in;
    logic          is_read;
    logic          unused_offset_bits;

    // Address decode, byte-lane selection and deskew completion for the current bus inputs
    always_comb begin
        cyc_in      = {bus.bus_c1, bus.bus_c0};
        offset      = bus.bus_addr - BASE;
        selected    = ({14'd0, bus.bus_addr} >= {14'd0, BASE}) &&
                      ({14'd0, bus.bus_addr} <  ({14'd0, BASE} + 32'(2 * WORDS)));
        // MSYN must have been high for DESKEW consecutive cycles, counting this one
        deskew_done = bus.bus_msyn &&
                      (((state == S_IDLE) && (DESKEW == 1)) ||
                       ((state == S_DESKEW) && ((int'(cnt) + 2) == DESKEW)));
        if (cyc_in == C_DATOB) begin
            be_in = bus.bus_addr[0] ? 2'b10 : 2'b01;
        end else begin
            be_in = 2'b11;
        end
        is_read = ~cyc[1];
    end

    assign unused_offset_bits = ^{offset[17:AW+1], offset[0]};

    // Bus cycle sequencer; INIT aborts exactly like reset and drops any pending RAM reply
    always_ff @(posedge clk) begin
        if (reset || bus.bus_init) begin
            state            <= S_IDLE;
            cnt              <= '0;
            cyc              <= 2'b00;
            bus.bus_ssyn_out <= 1'b0;
            bus.bus_d_en     <= 1'b0;
            bus.bus_d_out    <= 16'd0;
            mem_req          <= 1'b0;
            mem_we           <= 1'b0;
            mem_be           <= 2'b00;
            mem_addr         <= '0;
            mem_wdata        <= 16'd0;
            dip_lock         <= 1'b0;
        end else if (deskew_done) begin
            cyc <= cyc_in;
            if (selected) begin
                state     <= S_ACCESS;
                mem_req   <= 1'b1;
                mem_we    <= cyc_in[1];
                mem_be    <= be_in;
                mem_addr  <= offset[AW:1];
                mem_wdata <= bus.bus_d_in;
                dip_lock  <= 1'b0;
            end else begin
                state <= S_RELEASE;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.bus_msyn) begin
                        state <= S_DESKEW;
                        cnt   <= '0;
                    end
                end
                S_DESKEW: begin
                    if (!bus.bus_msyn) begin
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_ACCESS: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        mem_be  <= 2'b00;
                        if (is_read) begin
                            bus.bus_d_out <= mem_rdata;
                        end
                        // A master that gave up during the RAM access gets no SSYN
                        if (bus.bus_msyn) begin
                            state            <= S_RESPOND;
                            bus.bus_ssyn_out <= 1'b1;
                            bus.bus_d_en     <= is_read;
                            if (cyc == C_DATIP) begin
                                dip_lock <= 1'b1;
                            end
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                S_RESPOND: begin
                    if (!bus.bus_msyn) begin
                        state            <= S_RELEASE;
                        bus.bus_ssyn_out <= 1'b0;
                        bus.bus_d_en     <= 1'b0;
                    end
                end
                S_RELEASE: begin
                    if (!bus.bus_msyn) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_unibus_mem.sv
`default_nettype none
// ============================================================================
// Module      : tb_unibus_mem
// Description : Directed self-checking bench for unibus_mem with a simple
//               variable-latency RAM responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_unibus_mem;

    localparam int DESKEW = 4;
    localparam int WORDS  = 8192;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_req, mem_we, mem_ack, dip_lock;
    logic [1:0]  mem_be;
    logic [12:0] mem_addr;
    logic [15:0] mem_wdata, mem_rdata;

    logic        model_ack;
    logic        force_ack;
    int          lat;
    int          lat_cnt;
    logic [15:0] rd_val;

    int n_vec = 0;
    int n_err = 0;

    int          req_at, ssyn_at;
    logic        den_early, cap_we, cap_den, cap_dip;
    logic [1:0]  cap_be;
    logic [12:0] cap_addr;
    logic [15:0] cap_wdata, cap_dout;
    logic        seen;

    unibus_mem_if bus_if ();

    unibus_mem #(
        .BASE   (18'o000000),
        .WORDS  (WORDS),
        .DESKEW (DESKEW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus_if),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_be    (mem_be),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .dip_lock  (dip_lock)
    );

    always #5 clk = ~clk;

    assign mem_ack   = model_ack | force_ack;
    assign mem_rdata = rd_val;

    // RAM responder: ack arrives lat cycles after mem_req is first seen
    always @(posedge clk) begin
        if (reset || !mem_req || model_ack) begin
            model_ack <= 1'b0;
            lat_cnt   <= 0;
        end else if (lat_cnt + 1 >= lat) begin
            model_ack <= 1'b1;
            lat_cnt   <= 0;
        end else begin
            lat_cnt <= lat_cnt + 1;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0o expected=%0o", tag, obs, exp);
        end
    endtask

    // Start a bus cycle and watch it for up to limit cycles or until SSYN rises
    task automatic do_cycle(input logic [17:0] a, input logic [1:0] c,
                            input logic [15:0] d, input int limit);
        req_at    = -1;
        ssyn_at   = -1;
        den_early = 1'b0;
        cap_we    = 1'b0;
        cap_be    = 2'b00;
        cap_addr  = '0;
        cap_wdata = '0;
        cap_dip   = 1'b0;
        cap_den   = 1'b0;
        cap_dout  = '0;
        bus_if.bus_addr = a;
        bus_if.bus_c1   = c[1];
        bus_if.bus_c0   = c[0];
        bus_if.bus_d_in = d;
        bus_if.bus_msyn = 1'b1;
        for (int i = 1; i <= limit; i++) begin
            @(negedge clk);
            if (mem_req && req_at < 0) begin
                req_at    = i;
                cap_we    = mem_we;
                cap_be    = mem_be;
                cap_addr  = mem_addr;
                cap_wdata = mem_wdata;
                cap_dip   = dip_lock;
            end
            if (bus_if.bus_d_en && !bus_if.bus_ssyn_out) den_early = 1'b1;
            if (bus_if.bus_ssyn_out) begin
                ssyn_at  = i;
                cap_den  = bus_if.bus_d_en;
                cap_dout = bus_if.bus_d_out;
                break;
            end
        end
    endtask

    task automatic end_cycle(input string tag);
        bus_if.bus_msyn = 1'b0;
        @(negedge clk);
        check({tag, "_ssyn_drop"}, 32'(bus_if.bus_ssyn_out), 32'd0);
        check({tag, "_den_drop"},  32'(bus_if.bus_d_en),     32'd0);
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        reset           = 1'b1;
        force_ack       = 1'b0;
        lat             = 1;
        rd_val          = 16'd0;
        bus_if.bus_init = 1'b0;
        bus_if.bus_addr = 18'd0;
        bus_if.bus_c1   = 1'b0;
        bus_if.bus_c0   = 1'b0;
        bus_if.bus_msyn = 1'b0;
        bus_if.bus_d_in = 16'd0;
        repeat (3) @(negedge clk);

        check("rst_ssyn",  32'(bus_if.bus_ssyn_out), 32'd0);
        check("rst_den",   32'(bus_if.bus_d_en),     32'd0);
        check("rst_dout",  32'(bus_if.bus_d_out),    32'd0);
        check("rst_req",   32'(mem_req),             32'd0);
        check("rst_we",    32'(mem_we),              32'd0);
        check("rst_be",    32'(mem_be),              32'd0);
        check("rst_addr",  32'(mem_addr),            32'd0);
        check("rst_wdata", 32'(mem_wdata),           32'd0);
        check("rst_dip",   32'(dip_lock),            32'd0);
        reset = 1'b0;
        @(negedge clk);

        // DATO 000100, D=123456, latency 1
        do_cycle(18'o000100, 2'b10, 16'o123456, 20);
        check("dato_req_at", 32'(req_at),    32'(DESKEW));
        check("dato_we",     32'(cap_we),    32'd1);
        check("dato_be",     32'(cap_be),    32'b11);
        check("dato_addr",   32'(cap_addr),  32'o40);
        check("dato_wdata",  32'(cap_wdata), 32'o123456);
        check("dato_ssyn",   32'(ssyn_at),   32'(DESKEW + 2));
        check("dato_den",    32'(cap_den),   32'd0);
        end_cycle("dato");

        // DATI 000100, RAM returns 052525
        rd_val = 16'o052525;
        do_cycle(18'o000100, 2'b00, 16'd0, 20);
        check("dati_we",     32'(cap_we),    32'd0);
        check("dati_be",     32'(cap_be),    32'b11);
        check("dati_ssyn",   32'(ssyn_at),   32'(DESKEW + 2));
        check("dati_den",    32'(cap_den),   32'd1);
        check("dati_early",  32'(den_early), 32'd0);
        check("dati_dout",   32'(cap_dout),  32'o052525);
        end_cycle("dati");

        // DATOB odd byte, then even byte
        do_cycle(18'o000101, 2'b11, 16'o177400, 20);
        check("datob_hi_be",    32'(cap_be),    32'b10);
        check("datob_hi_addr",  32'(cap_addr),  32'o40);
        check("datob_hi_wdata", 32'(cap_wdata), 32'o177400);
        check("datob_hi_ssyn",  32'(ssyn_at),   32'(DESKEW + 2));
        end_cycle("datob_hi");
        do_cycle(18'o000100, 2'b11, 16'o000377, 20);
        check("datob_lo_be",    32'(cap_be),    32'b01);
        check("datob_lo_ssyn",  32'(ssyn_at),   32'(DESKEW + 2));
        end_cycle("datob_lo");

        // DATI with RAM latency 3
        lat    = 3;
        rd_val = 16'o001234;
        do_cycle(18'o000200, 2'b00, 16'd0, 20);
        check("lat3_addr", 32'(cap_addr), 32'o100);
        check("lat3_ssyn", 32'(ssyn_at),  32'(DESKEW + 4));
        check("lat3_dout", 32'(cap_dout), 32'o001234);
        end_cycle("lat3");
        lat = 1;

        // Just outside the window: no RAM request and no response
        do_cycle(18'o040000, 2'b00, 16'd0, 3 * DESKEW + 6);
        check("oow_req",  32'(req_at),    32'hFFFF_FFFF);
        check("oow_ssyn", 32'(ssyn_at),   32'hFFFF_FFFF);
        check("oow_den",  32'(den_early), 32'd0);
        end_cycle("oow");

        // Top word of the window is served normally afterwards
        rd_val = 16'o111111;
        do_cycle(18'o037776, 2'b00, 16'd0, 20);
        check("top_addr", 32'(cap_addr), 32'o17777);
        check("top_ssyn", 32'(ssyn_at),  32'(DESKEW + 2));
        check("top_dout", 32'(cap_dout), 32'o111111);
        end_cycle("top");

        // MSYN high for only DESKEW-1 cycles
        seen = 1'b0;
        bus_if.bus_addr = 18'o000100;
        bus_if.bus_c1   = 1'b0;
        bus_if.bus_c0   = 1'b0;
        bus_if.bus_msyn = 1'b1;
        for (int i = 0; i < DESKEW - 1; i++) begin
            @(negedge clk);
            if (mem_req) seen = 1'b1;
        end
        bus_if.bus_msyn = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (mem_req || bus_if.bus_ssyn_out) seen = 1'b1;
        end
        check("short_msyn", 32'(seen), 32'd0);

        // MSYN drops during ACCESS: RAM finishes, SSYN never rises
        lat = 3;
        do_cycle(18'o000100, 2'b00, 16'd0, DESKEW);
        check("abort_req_at", 32'(req_at), 32'(DESKEW));
        bus_if.bus_msyn = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus_if.bus_ssyn_out || bus_if.bus_d_en) seen = 1'b1;
        end
        check("abort_ssyn", 32'(seen),    32'd0);
        check("abort_req",  32'(mem_req), 32'd0);

        // INIT during ACCESS with an ack pending, then a stray ack
        lat = 4;
        do_cycle(18'o000300, 2'b10, 16'o055555, DESKEW);
        check("init_req_at", 32'(req_at), 32'(DESKEW));
        bus_if.bus_init = 1'b1;
        @(negedge clk);
        bus_if.bus_init = 1'b0;
        bus_if.bus_msyn = 1'b0;
        check("init_req",   32'(mem_req),             32'd0);
        check("init_we",    32'(mem_we),              32'd0);
        check("init_be",    32'(mem_be),              32'd0);
        check("init_addr",  32'(mem_addr),            32'd0);
        check("init_wdata", 32'(mem_wdata),           32'd0);
        check("init_ssyn",  32'(bus_if.bus_ssyn_out), 32'd0);
        rd_val    = 16'o007777;
        force_ack = 1'b1;
        @(negedge clk);
        force_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("stray_ssyn", 32'(bus_if.bus_ssyn_out), 32'd0);
        check("stray_den",  32'(bus_if.bus_d_en),     32'd0);
        check("stray_dout", 32'(bus_if.bus_d_out),    32'd0);
        check("stray_req",  32'(mem_req),             32'd0);
        lat = 1;

        // DATIP sets dip_lock; the next selected cycle clears it
        rd_val = 16'o070707;
        do_cycle(18'o000100, 2'b01, 16'd0, 20);
        check("datip_ssyn", 32'(ssyn_at),  32'(DESKEW + 2));
        check("datip_den",  32'(cap_den),  32'd1);
        check("datip_dout", 32'(cap_dout), 32'o070707);
        check("datip_lock", 32'(dip_lock), 32'd1);
        end_cycle("datip");
        check("lock_held", 32'(dip_lock), 32'd1);
        do_cycle(18'o000102, 2'b10, 16'o000001, 20);
        check("lock_clr", 32'(cap_dip),  32'd0);
        check("lock_we",  32'(cap_we),   32'd1);
        check("lock_addr", 32'(cap_addr), 32'o41);
        end_cycle("lock");
        check("lock_after", 32'(dip_lock), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
